// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract engine: one operand bit per cycle through a 1-bit full adder, LSB first.
// Optional build macro ZERO_FLAG_EN adds a serially accumulated Zero flag output.
module serial_adder_ctrl #(
  parameter int WIDTH = 128
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic             Sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Result,
  output logic             Cout,
`ifdef ZERO_FLAG_EN
  output logic             Zero,
`endif
  output logic             Overflow
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sha_q, sha_d;
  logic [WIDTH-1:0] shb_q, shb_d;
  logic [WIDTH-1:0] res_sh_q, res_sh_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             msb_cin_q, msb_cin_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;
`ifdef ZERO_FLAG_EN
  logic             zacc_q, zacc_d;
  logic             zero_q, zero_d;
`endif

  logic fa_sum, fa_co;

  // Full-adder cell on the current LSBs of the shift registers
  assign fa_sum = sha_q[0] ^ shb_q[0] ^ carry_q;
  assign fa_co  = (sha_q[0] & shb_q[0]) | (sha_q[0] & carry_q) | (shb_q[0] & carry_q);

  always_comb begin
    state_d   = state_q;
    sha_d     = sha_q;
    shb_d     = shb_q;
    res_sh_d  = res_sh_q;
    result_d  = result_q;
    cnt_d     = cnt_q;
    carry_d   = carry_q;
    msb_cin_d = msb_cin_q;
    cout_d    = cout_q;
    ovf_d     = ovf_q;
    done_d    = 1'b0;
`ifdef ZERO_FLAG_EN
    zacc_d    = zacc_q;
    zero_d    = zero_q;
`endif
    case (state_q)
      IDLE: begin
        if (Start) begin
          sha_d   = A;
          shb_d   = Sub ? ~B : B;
          carry_d = Sub ? 1'b1 : Cin;
          cnt_d   = '0;
`ifdef ZERO_FLAG_EN
          zacc_d  = 1'b0;
`endif
          state_d = RUN;
        end
      end
      RUN: begin
        carry_d  = fa_co;
        res_sh_d = {fa_sum, res_sh_q[WIDTH-1:1]};
        sha_d    = sha_q >> 1;
        shb_d    = shb_q >> 1;
        cnt_d    = cnt_q + CW'(1);
`ifdef ZERO_FLAG_EN
        zacc_d   = zacc_q | fa_sum;
`endif
        if (cnt_q == LAST) begin
          // Carry into the MSB is needed for signed overflow
          msb_cin_d = carry_q;
          state_d   = FINISH;
        end
      end
      FINISH: begin
        result_d = res_sh_q;
        cout_d   = carry_q;
        ovf_d    = msb_cin_q ^ carry_q;
        done_d   = 1'b1;
`ifdef ZERO_FLAG_EN
        zero_d   = ~zacc_q;
`endif
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= IDLE;
      sha_q     <= '0;
      shb_q     <= '0;
      res_sh_q  <= '0;
      result_q  <= '0;
      cnt_q     <= '0;
      carry_q   <= 1'b0;
      msb_cin_q <= 1'b0;
      cout_q    <= 1'b0;
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
`ifdef ZERO_FLAG_EN
      zacc_q    <= 1'b0;
      zero_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      sha_q     <= sha_d;
      shb_q     <= shb_d;
      res_sh_q  <= res_sh_d;
      result_q  <= result_d;
      cnt_q     <= cnt_d;
      carry_q   <= carry_d;
      msb_cin_q <= msb_cin_d;
      cout_q    <= cout_d;
      ovf_q     <= ovf_d;
      done_q    <= done_d;
`ifdef ZERO_FLAG_EN
      zacc_q    <= zacc_d;
      zero_q    <= zero_d;
`endif
    end
  end

  assign Busy     = (state_q != IDLE);
  assign Done     = done_q;
  assign Result   = result_q;
  assign Cout     = cout_q;
  assign Overflow = ovf_q;
`ifdef ZERO_FLAG_EN
  assign Zero     = zero_q;
`endif

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl: vector table plus reset, busy, back-to-back sequences.
module tb_serial_adder_ctrl;
  localparam int W      = 128;
  localparam int BUDGET = W + 20;

  logic         Clk = 1'b0;
  logic         Reset_n, Start, Sub, Cin;
  logic [W-1:0] A, B;
  logic         Busy, Done, Cout, Overflow;
  logic [W-1:0] Result;
`ifdef ZERO_FLAG_EN
  logic         Zero;
`endif

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Sub(Sub), .A(A), .B(B), .Cin(Cin),
    .Busy(Busy), .Done(Done), .Result(Result), .Cout(Cout),
`ifdef ZERO_FLAG_EN
    .Zero(Zero),
`endif
    .Overflow(Overflow)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [W-1:0] a, b;
    logic         sub, cin;
    logic [W-1:0] res;
    logic         cout, ovf;
  } vec_t;

  vec_t vecs[8];
  int   total = 0;
  int   passed = 0;

  localparam logic [W-1:0] ONES = {W{1'b1}};
  localparam logic [W-1:0] MSB  = {1'b1, {(W-1){1'b0}}};

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub, input logic cin);
    A = a; B = b; Sub = sub; Cin = cin; Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
  endtask

  // Counts negedges until Done is seen (bounded)
  task automatic wait_done(output int lat);
    lat = 0;
    while (!Done && lat < BUDGET) begin
      @(negedge Clk);
      lat++;
    end
  endtask

  task automatic count_dones(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge Clk);
      if (Done) n++;
    end
  endtask

  initial begin
    int lat, n;
    vecs[0] = '{a: 5,        b: 3,    sub: 0, cin: 0, res: 8,        cout: 0, ovf: 0};
    vecs[1] = '{a: ONES,     b: 1,    sub: 0, cin: 0, res: 0,        cout: 1, ovf: 0};
    vecs[2] = '{a: MSB,      b: 1,    sub: 1, cin: 0, res: ~MSB,     cout: 1, ovf: 1};
    vecs[3] = '{a: 3,        b: 5,    sub: 1, cin: 0, res: ONES - 1, cout: 0, ovf: 0};
    vecs[4] = '{a: 7,        b: 8,    sub: 0, cin: 1, res: 16,       cout: 0, ovf: 0};
    vecs[5] = '{a: 5,        b: 5,    sub: 1, cin: 0, res: 0,        cout: 1, ovf: 0};
    vecs[6] = '{a: ~MSB,     b: 1,    sub: 0, cin: 0, res: MSB,      cout: 0, ovf: 1};
    vecs[7] = '{a: 10,       b: 3,    sub: 1, cin: 0, res: 7,        cout: 1, ovf: 0};

    Reset_n = 1'b0; Start = 0; Sub = 0; Cin = 0; A = '0; B = '0;
    repeat (2) @(negedge Clk);
    chk("reset_busy", Busy, 0);
    chk("reset_done", Done, 0);
    chk("reset_result", Result, 0);
    chk("reset_cout", Cout, 0);
    chk("reset_ovf", Overflow, 0);
`ifdef ZERO_FLAG_EN
    chk("reset_zero", Zero, 0);
`endif
    Reset_n = 1'b1;
    @(negedge Clk);

    for (int i = 0; i < 8; i++) begin
      start_op(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].cin);
      chk($sformatf("v%0d_busy", i), Busy, 1);
      wait_done(lat);
      chk($sformatf("v%0d_latency", i), lat, W + 1);
      chk($sformatf("v%0d_result", i), Result, vecs[i].res);
      chk($sformatf("v%0d_cout", i), Cout, vecs[i].cout);
      chk($sformatf("v%0d_ovf", i), Overflow, vecs[i].ovf);
      chk($sformatf("v%0d_busy_done", i), Busy, 0);
`ifdef ZERO_FLAG_EN
      chk($sformatf("v%0d_zero", i), Zero, (vecs[i].res == '0));
`endif
      @(negedge Clk);
      chk($sformatf("v%0d_done_1cyc", i), Done, 0);
      chk($sformatf("v%0d_result_hold", i), Result, vecs[i].res);
    end

    // Start during RUN must be ignored
    start_op(10, 20, 0, 0);
    repeat (5) @(negedge Clk);
    A = 99; Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    chk("busy_prot_old_result", Result, 7);
    wait_done(lat);
    chk("busy_prot_latency", lat, W - 5);
    chk("busy_prot_result", Result, 30);
    count_dones(W + 10, n);
    chk("busy_prot_one_done", n, 0);

    // Back-to-back: new Start in the Done cycle
    start_op(1, 2, 0, 0);
    wait_done(lat);
    chk("b2b_first_result", Result, 3);
    start_op(4, 4, 0, 0);
    n = 1;
    chk("b2b_busy", Busy, 1);
    chk("b2b_result_stable", Result, 3);
    while (!Done && n < BUDGET) begin
      @(negedge Clk);
      n++;
    end
    chk("b2b_spacing", n, W + 2);
    chk("b2b_second_result", Result, 8);

    // Reset asserted mid-RUN clears immediately, no Done follows
    @(negedge Clk);
    start_op(ONES, 1, 0, 0);
    repeat (10) @(negedge Clk);
    Reset_n = 1'b0;
    #1;
    chk("rst_run_busy", Busy, 0);
    chk("rst_run_done", Done, 0);
    chk("rst_run_result", Result, 0);
    chk("rst_run_cout", Cout, 0);
    chk("rst_run_ovf", Overflow, 0);
    @(negedge Clk);
    Reset_n = 1'b1;
    count_dones(W + 10, n);
    chk("rst_run_no_done", n, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
